// File: rtl/pc_unit.sv
// Fetch-stage program counter and next-PC selector with a BOOT/RUN/TRAP sequencer.
// It keeps the exception PC for ERET and does not overwrite it on nested exceptions.
module pc_unit #(
    parameter int unsigned        WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0040_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned        INC          = 4,
    parameter bit                 ALIGN_CHECK  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_TARGET,
    input  logic             JMP,
    input  logic [WIDTH-1:0] JMP_TARGET,
    input  logic             EXC_REQ,
    input  logic             ERET,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] PC_NEXT_SEQ,
    output logic [WIDTH-1:0] EPC,
    output logic             ADDR_ERR,
    output logic             IN_TRAP,
    output logic             VALID
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TRAP = 2'd2;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             aerr_q, aerr_d;

    logic             redirect;
    logic [WIDTH-1:0] sel_target;
    logic             misaligned;
    logic [WIDTH-1:0] pc_seq;

    assign pc_seq     = pc_q + INC_W;
    assign redirect   = !STALL && (JMP || BR_TAKEN);
    assign sel_target = JMP ? JMP_TARGET : BR_TARGET;
    // Only a target that would actually be loaded this cycle can fault.
    assign misaligned = ALIGN_CHECK && redirect && (sel_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        aerr_d  = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
            pc_d    = pc_seq;
        end else if (EXC_REQ || misaligned) begin
            pc_d    = EXC_VECTOR;
            state_d = TRAP;
            aerr_d  = misaligned;
            if (state_q != TRAP) begin
                epc_d = pc_q;
            end
        end else if (ERET && (state_q == TRAP)) begin
            pc_d    = epc_q;
            state_d = RUN;
        end else if (redirect) begin
            pc_d = sel_target;
        end else if (!STALL) begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            aerr_q  <= aerr_d;
        end
    end

    assign PC_OUT      = pc_q;
    assign PC_NEXT_SEQ = pc_seq;
    assign EPC         = epc_q;
    assign ADDR_ERR    = aerr_q;
    assign IN_TRAP     = (state_q == TRAP);
    assign VALID       = (state_q != BOOT);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random traffic, two instances
// (alignment checking on and off) compared against a behavioural model.
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RST, STALL, BR_TAKEN, JMP, EXC_REQ, ERET;
    logic [31:0] BR_TARGET, JMP_TARGET;

    logic [31:0] d_pc [2];
    logic [31:0] d_seq[2];
    logic [31:0] d_epc[2];
    logic        d_aerr[2];
    logic        d_trap[2];
    logic        d_valid[2];

    // model state, index 0 = alignment checked, 1 = unchecked
    logic [31:0] m_pc [2];
    logic [31:0] m_epc[2];
    bit          m_aerr[2];
    bit          m_trap[2];
    bit          m_boot[2];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_unit #(.ALIGN_CHECK(1'b1)) u_dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .JMP(JMP), .JMP_TARGET(JMP_TARGET), .EXC_REQ(EXC_REQ), .ERET(ERET),
        .PC_OUT(d_pc[0]), .PC_NEXT_SEQ(d_seq[0]), .EPC(d_epc[0]), .ADDR_ERR(d_aerr[0]),
        .IN_TRAP(d_trap[0]), .VALID(d_valid[0])
    );

    pc_unit #(.ALIGN_CHECK(1'b0)) u_dut_na (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .JMP(JMP), .JMP_TARGET(JMP_TARGET), .EXC_REQ(EXC_REQ), .ERET(ERET),
        .PC_OUT(d_pc[1]), .PC_NEXT_SEQ(d_seq[1]), .EPC(d_epc[1]), .ADDR_ERR(d_aerr[1]),
        .IN_TRAP(d_trap[1]), .VALID(d_valid[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit          align = (i == 0);
            bit          take  = !STALL && (JMP || BR_TAKEN);
            logic [31:0] tgt   = JMP ? JMP_TARGET : BR_TARGET;
            bit          bad   = align && take && (tgt % 4 != 0);
            if (!RST) begin
                m_pc[i] = 32'h0040_0000; m_epc[i] = 0; m_aerr[i] = 0; m_trap[i] = 0; m_boot[i] = 1;
            end else if (m_boot[i]) begin
                m_boot[i] = 0; m_aerr[i] = 0; m_pc[i] = m_pc[i] + 4;
            end else begin
                m_aerr[i] = bad;
                if (EXC_REQ || bad) begin
                    if (!m_trap[i]) m_epc[i] = m_pc[i];
                    m_pc[i]   = 32'h8000_0180;
                    m_trap[i] = 1;
                end else if (ERET && m_trap[i]) begin
                    m_pc[i]   = m_epc[i];
                    m_trap[i] = 0;
                end else if (take) begin
                    m_pc[i] = tgt;
                end else if (!STALL) begin
                    m_pc[i] = m_pc[i] + 4;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("pc%0d", i),    d_pc[i],    m_pc[i]);
            check_eq($sformatf("seq%0d", i),   d_seq[i],   m_pc[i] + 32'd4);
            check_eq($sformatf("epc%0d", i),   d_epc[i],   m_epc[i]);
            check_eq($sformatf("aerr%0d", i),  32'(d_aerr[i]),  32'(m_aerr[i]));
            check_eq($sformatf("trap%0d", i),  32'(d_trap[i]),  32'(m_trap[i]));
            check_eq($sformatf("valid%0d", i), 32'(d_valid[i]), 32'(!m_boot[i]));
        end
    endtask

    task automatic idle();
        STALL = 0; BR_TAKEN = 0; JMP = 0; EXC_REQ = 0; ERET = 0;
        BR_TARGET = '0; JMP_TARGET = '0;
    endtask

    initial begin
        idle();
        RST = 0;
        cycle(); cycle();
        RST = 1;
        check_eq("rst_pc", d_pc[0], 32'h0040_0000);
        check_eq("rst_valid", 32'(d_valid[0]), 32'd0);
        check_eq("rst_epc", d_epc[0], 32'd0);
        cycle(); check_eq("boot1", d_pc[0], 32'h0040_0004);
        check_eq("valid1", 32'(d_valid[0]), 32'd1);
        cycle(); check_eq("boot2", d_pc[0], 32'h0040_0008);

        BR_TAKEN = 1; BR_TARGET = 32'h0040_0100;
        cycle(); check_eq("branch", d_pc[0], 32'h0040_0100);
        JMP = 1; JMP_TARGET = 32'h0040_1000;
        cycle(); check_eq("jmp_wins", d_pc[0], 32'h0040_1000);
        idle(); STALL = 1; JMP = 1; JMP_TARGET = 32'h0000_0100;
        repeat (3) begin
            cycle(); check_eq("stall", d_pc[0], 32'h0040_1000);
        end

        idle(); JMP = 1; JMP_TARGET = 32'h0040_0020;
        cycle();
        idle(); STALL = 1; EXC_REQ = 1;
        cycle(); check_eq("exc_pc", d_pc[0], 32'h8000_0180);
        check_eq("exc_epc", d_epc[0], 32'h0040_0020);
        check_eq("exc_trap", 32'(d_trap[0]), 32'd1);
        idle();
        cycle(); check_eq("trap_seq", d_pc[0], 32'h8000_0184);
        EXC_REQ = 1;
        cycle(); check_eq("nest_pc", d_pc[0], 32'h8000_0180);
        check_eq("nest_epc", d_epc[0], 32'h0040_0020);
        idle(); ERET = 1;
        cycle(); check_eq("eret_pc", d_pc[0], 32'h0040_0020);
        check_eq("eret_trap", 32'(d_trap[0]), 32'd0);
        cycle(); check_eq("eret_run", d_pc[0], 32'h0040_0024);

        idle(); JMP = 1; JMP_TARGET = 32'h0040_0010;
        cycle();
        idle(); BR_TAKEN = 1; BR_TARGET = 32'h0040_0102;
        cycle(); check_eq("mis_aerr", 32'(d_aerr[0]), 32'd1);
        check_eq("mis_pc", d_pc[0], 32'h8000_0180);
        check_eq("mis_epc", d_epc[0], 32'h0040_0010);
        check_eq("noalign_pc", d_pc[1], 32'h0040_0102);
        check_eq("noalign_aerr", 32'(d_aerr[1]), 32'd0);
        idle();
        cycle(); check_eq("aerr_pulse", 32'(d_aerr[0]), 32'd0);
        ERET = 1;
        cycle();

        idle(); JMP = 1; JMP_TARGET = 32'hFFFF_FFFC;
        cycle(); check_eq("seq_top", d_seq[0], 32'h0000_0000);
        idle();
        cycle(); check_eq("wrap", d_pc[0], 32'h0000_0000);
        EXC_REQ = 1;
        cycle();
        idle(); RST = 0;
        cycle(); check_eq("trst_pc", d_pc[0], 32'h0040_0000);
        check_eq("trst_trap", 32'(d_trap[0]), 32'd0);
        check_eq("trst_epc", d_epc[0], 32'd0);
        RST = 1;

        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(63) != 0);
            STALL      = ($urandom_range(4) == 0);
            EXC_REQ    = ($urandom_range(15) == 0);
            ERET       = ($urandom_range(7) == 0);
            JMP        = ($urandom_range(7) == 0);
            BR_TAKEN   = ($urandom_range(5) == 0);
            JMP_TARGET = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            BR_TARGET  = $urandom() & 32'hFFFF_FFFC;
            // misaligned targets only where their treatment is unambiguous
            if (!STALL && !ERET && $urandom_range(7) == 0) begin
                JMP_TARGET[1:0] = 2'($urandom_range(1, 3));
                BR_TARGET[1:0]  = 2'($urandom_range(1, 3));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d exp %0d", checks, 0);
        $fatal(1);
    end

endmodule
